// File: rtl/video_window_fetch_if.sv
// Frame-buffer read port between video_window_fetch and the frame-buffer memory.
//   mem_addr : read address (driven by the fetch stage)
//   mem_rd   : read strobe (driven by the fetch stage)
//   mem_data : 24-bit RGB read data (driven by the memory)
//
// Handshake: mem_rd=1 marks the cycle in which mem_addr is a valid read
// request. There is no ready signal because the memory accepts a request on
// every cycle. The memory returns mem_data exactly MEM_LAT cycles after the
// request cycle, whether or not mem_rd was high. The fetch stage only uses
// the returned data for cycles that were real requests.
interface video_window_fetch_if #(
  parameter int AW = 19
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [23:0]   mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/video_window_fetch.sv
// video_window_fetch: pixel-fetch stage upstream of the colour filter.
// It decides whether each raster position lies inside the display window.
// For in-window pixels it reads RGB from the frame buffer. Syncs and blank
// are delayed by the same latency as the pixel data.
//
// Ports:
//   clk, reset        pixel clock; synchronous active-high reset
//   hcount, vcount    raster position
//   hsync_in, vsync_in, blank_in
//                     active-low syncs; blank_in is high during blanking
//   option_req        requested filter option
//   mem               frame-buffer read port (master side)
//   rgb, in_frame     pixel and window flag, L = MEM_LAT+2 cycles after input
//   option            filter option, latched once per frame
//   hsync_out, vsync_out, blank_out
//                     syncs and blank delayed by L cycles
//   frame_count       frame counter, wraps at 256
module video_window_fetch #(
  parameter int X0      = 64,
  parameter int Y0      = 48,
  parameter int W       = 640,
  parameter int H       = 480,
  parameter int MEM_LAT = 2,
  parameter int AW      = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 blank_in,
  input  logic [1:0]           option_req,
  video_window_fetch_if.master mem,
  output logic [23:0]          rgb,
  output logic                 in_frame,
  output logic [1:0]           option,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 blank_out,
  output logic [7:0]           frame_count
);

  localparam int L = MEM_LAT + 2;

  // Window bounds as 12-bit constants. The extra bit keeps X0+W and Y0+H
  // from overflowing the raster counter widths.
  localparam logic [11:0]   H_LO   = 12'(X0);
  localparam logic [11:0]   H_HI   = 12'(X0 + W);
  localparam logic [11:0]   V_LO   = 12'(Y0);
  localparam logic [11:0]   V_HI   = 12'(Y0 + H);
  localparam logic [AW-1:0] A_LAST = AW'(W * H - 1);

  logic [11:0]   h_ext;
  logic [11:0]   v_ext;
  logic          win;
  logic          fs;
  logic          vsync_q;
  logic [AW-1:0] acnt;

  // Bit 0 is stage 1 and bit L-1 is stage L, which drives the outputs.
  logic [L-1:0]  win_pipe;
  logic [L-1:0]  hs_pipe;
  logic [L-1:0]  vs_pipe;
  logic [L-1:0]  bl_pipe;

  assign h_ext = {1'b0, hcount};
  assign v_ext = {2'b00, vcount};
  assign win   = (h_ext >= H_LO) && (h_ext < H_HI) &&
                 (v_ext >= V_LO) && (v_ext < V_HI);

  // Frame start is the first cycle with vsync low.
  assign fs = vsync_q && !vsync_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q      <= 1'b1;
      acnt         <= '0;
      mem.mem_addr <= '0;
      mem.mem_rd   <= 1'b0;
      win_pipe     <= '0;
      hs_pipe      <= '1;
      vs_pipe      <= '1;
      bl_pipe      <= '1;
      rgb          <= 24'h000000;
      option       <= 2'b00;
      frame_count  <= 8'd0;
    end else begin
      vsync_q <= vsync_in;

      // Pixels arrive in raster order, so a running count gives y*W+x
      // without a multiplier. The frame-start clear wins over an increment.
      if (fs) begin
        acnt <= '0;
      end else if (win) begin
        acnt <= (acnt == A_LAST) ? '0 : acnt + AW'(1);
      end

      mem.mem_rd <= win;
      if (win) begin
        mem.mem_addr <= acnt;
      end

      win_pipe <= {win_pipe[L-2:0], win};
      hs_pipe  <= {hs_pipe[L-2:0], hsync_in};
      vs_pipe  <= {vs_pipe[L-2:0], vsync_in};
      bl_pipe  <= {bl_pipe[L-2:0], blank_in};

      // Read data for the stage-(L-1) pixel is on mem_data this cycle.
      rgb <= win_pipe[L-2] ? mem.mem_data : 24'h000000;

      // Latching only at frame start means the filter never sees a
      // mid-frame option change.
      if (fs) begin
        option      <= option_req;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign in_frame  = win_pipe[L-1];
  assign hsync_out = hs_pipe[L-1];
  assign vsync_out = vs_pipe[L-1];
  assign blank_out = bl_pipe[L-1];

endmodule

// File: tb/tb_video_window_fetch.sv
// Directed testbench for video_window_fetch.
// Instance dut uses the default parameters.
// Instance dut_s uses a small window (4x3, MEM_LAT=1) so that a whole frame
// and the address wrap can be covered quickly.
module tb_video_window_fetch;

  localparam int MAXC = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in, vsync_in, blank_in;
  logic [1:0]  option_req;
  logic [23:0] rgb;
  logic        in_frame;
  logic [1:0]  option;
  logic        hsync_out, vsync_out, blank_out;
  logic [7:0]  frame_count;

  video_window_fetch_if #(.AW(19)) m ();

  video_window_fetch dut (
    .clk(clk), .reset(reset),
    .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .option_req(option_req),
    .mem(m),
    .rgb(rgb), .in_frame(in_frame), .option(option),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .frame_count(frame_count)
  );

  function automatic logic [23:0] mem_fn(input logic [18:0] a);
    return 24'hA5A5A5 ^ {5'b00000, a};
  endfunction

  // Frame-buffer model with a 2-cycle read latency.
  logic [23:0] md1, md2;
  always @(posedge clk) begin
    md1 <= mem_fn(m.mem_addr);
    md2 <= md1;
  end
  assign m.mem_data = md2;

  // ---------------- small DUT ----------------
  logic [10:0] h2;
  logic [9:0]  v2;
  logic        vs2;
  logic [23:0] s_rgb_o;
  logic        s_inf_o;
  logic [1:0]  s_opt_o;
  logic        s_hs_o, s_vs_o, s_bl_o;
  logic [7:0]  s_fc_o;

  video_window_fetch_if #(.AW(4)) s ();

  video_window_fetch #(.X0(2), .Y0(1), .W(4), .H(3), .MEM_LAT(1), .AW(4)) dut_s (
    .clk(clk), .reset(reset),
    .hcount(h2), .vcount(v2),
    .hsync_in(1'b1), .vsync_in(vs2), .blank_in(1'b0),
    .option_req(2'b00),
    .mem(s),
    .rgb(s_rgb_o), .in_frame(s_inf_o), .option(s_opt_o),
    .hsync_out(s_hs_o), .vsync_out(s_vs_o), .blank_out(s_bl_o),
    .frame_count(s_fc_o)
  );

  // Frame-buffer model with a 1-cycle read latency.
  logic [23:0] sd1;
  always @(posedge clk) sd1 <= mem_fn(19'(s.mem_addr));
  assign s.mem_data = sd1;

  // ---------------- per-cycle record ----------------
  // Index c is the cycle number. Inputs are recorded for the cycle in which
  // they were applied, and outputs for the cycle in which they are visible.
  int c = 0;
  logic [18:0] r_addr[MAXC];
  logic        r_rd[MAXC];
  logic [23:0] r_rgb[MAXC];
  logic        r_inf[MAXC], r_hs[MAXC], r_vs[MAXC], r_bl[MAXC];
  logic        i_hs[MAXC], i_vs[MAXC], i_bl[MAXC];
  logic [3:0]  s_addr[MAXC];
  logic        s_rd[MAXC];
  logic [23:0] s_rgb[MAXC];
  logic        s_inf[MAXC];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    i_hs[c] = hsync_in;
    i_vs[c] = vsync_in;
    i_bl[c] = blank_in;
    @(posedge clk);
    #1;
    c++;
    r_addr[c] = m.mem_addr;
    r_rd[c]   = m.mem_rd;
    r_rgb[c]  = rgb;
    r_inf[c]  = in_frame;
    r_hs[c]   = hsync_out;
    r_vs[c]   = vsync_out;
    r_bl[c]   = blank_out;
    s_addr[c] = s.mem_addr;
    s_rd[c]   = s.mem_rd;
    s_rgb[c]  = s_rgb_o;
    s_inf[c]  = s_inf_o;
  endtask

  task automatic px(input int h, input int v, input logic hs, input logic vs, input logic bl);
    hcount   = 11'(h);
    vcount   = 10'(v);
    hsync_in = hs;
    vsync_in = vs;
    blank_in = bl;
    step();
  endtask

  task automatic px2(input int h, input int v, input logic vs);
    h2  = 11'(h);
    v2  = 10'(v);
    vs2 = vs;
    step();
  endtask

  task automatic fs_pulse();
    px(0, 0, 1'b1, 1'b0, 1'b1);
    px(0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, t_last, t_out, t_r1, ts, t_e, t_a, t_w, t_b, n;

    reset = 1'b1;
    option_req = 2'b00;
    hcount = '0; vcount = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    h2 = '0; v2 = '0; vs2 = 1'b1;

    // Reset state.
    step();
    step();
    chk("rst_rgb",       32'(rgb),         32'h0);
    chk("rst_in_frame",  32'(in_frame),    32'h0);
    chk("rst_mem_rd",    32'(m.mem_rd),    32'h0);
    chk("rst_mem_addr",  32'(m.mem_addr),  32'h0);
    chk("rst_option",    32'(option),      32'h0);
    chk("rst_frame_cnt", 32'(frame_count), 32'h0);
    chk("rst_hsync_out", 32'(hsync_out),   32'h1);
    chk("rst_vsync_out", 32'(vsync_out),   32'h1);
    chk("rst_blank_out", 32'(blank_out),   32'h1);

    // First frame start latches option 2.
    reset = 1'b0;
    option_req = 2'd2;
    px(0, 0, 1'b1, 1'b1, 1'b1);
    chk("pre_fs_option", 32'(option),      32'h0);
    chk("pre_fs_fcnt",   32'(frame_count), 32'h0);
    px(0, 0, 1'b1, 1'b0, 1'b1);
    chk("fs_option",     32'(option),      32'h2);
    chk("fs_fcnt",       32'(frame_count), 32'h1);
    px(0, 0, 1'b1, 1'b1, 1'b1);

    // Full first window row, one pixel past it, then the start of row 49.
    // option_req changes mid-row and must not reach option.
    t0 = c;
    for (int x = 64; x <= 704; x++) begin
      if (x == 300) option_req = 2'd3;
      px(x, 48, 1'b1, 1'b1, 1'b0);
    end
    t_last = t0 + 639;
    t_out  = t0 + 640;
    t_r1   = c;
    px(64, 49, 1'b1, 1'b1, 1'b0);
    px(65, 49, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) px(0, 49, 1'b1, 1'b1, 1'b1);

    chk("first_addr",     32'(r_addr[t0+1]),    32'd0);
    chk("first_rd",       32'(r_rd[t0+1]),      32'd1);
    chk("first_rgb",      32'(r_rgb[t0+4]),     32'hA5A5A5);
    chk("first_in_frame", 32'(r_inf[t0+4]),     32'd1);
    chk("second_addr",    32'(r_addr[t0+2]),    32'd1);
    chk("row_end_addr",   32'(r_addr[t_last+1]), 32'd639);
    chk("row_end_rd",     32'(r_rd[t_last+1]),  32'd1);
    chk("row_end_rgb",    32'(r_rgb[t_last+4]), 32'hA5A7DA);
    chk("past_row_rd",    32'(r_rd[t_out+1]),   32'd0);
    chk("past_row_hold",  32'(r_addr[t_out+1]), 32'd639);
    chk("past_row_inf",   32'(r_inf[t_out+4]),  32'd0);
    chk("past_row_rgb",   32'(r_rgb[t_out+4]),  32'h0);
    chk("row49_addr",     32'(r_addr[t_r1+1]),  32'd640);
    chk("row49_rgb",      32'(r_rgb[t_r1+4]),   32'hA5A725);
    chk("row49_inf",      32'(r_inf[t_r1+4]),   32'd1);
    chk("row49_addr2",    32'(r_addr[t_r1+2]),  32'd641);
    chk("midframe_option", 32'(option),         32'h2);
    chk("midframe_fcnt",   32'(frame_count),    32'h1);

    // Sync alignment on a random raster. Blank is high exactly when the
    // position is outside the window.
    ts = c;
    for (int k = 0; k < 60; k++) begin
      logic inwin;
      inwin = 1'($urandom_range(0, 1));
      px(inwin ? 100 : 10, 100, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), !inwin);
    end
    for (int k = 0; k < 4; k++) px(10, 100, 1'b1, 1'b1, 1'b1);
    for (int k = ts + 4; k < ts + 64; k++) begin
      chk("hsync_delay",  32'(r_hs[k]),  32'(i_hs[k-4]));
      chk("vsync_delay",  32'(r_vs[k]),  32'(i_vs[k-4]));
      chk("blank_delay",  32'(r_bl[k]),  32'(i_bl[k-4]));
      chk("inf_vs_blank", 32'(r_inf[k]), 32'(!i_bl[k-4]));
    end

    // Reset in the middle of a frame with window pixels in flight.
    fs_pulse();
    chk("pre_reset_option", 32'(option), 32'h3);
    px(298, 200, 1'b0, 1'b1, 1'b0);
    px(299, 200, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    px(300, 200, 1'b0, 1'b1, 1'b0);
    chk("mid_rst_rgb",       32'(rgb),         32'h0);
    chk("mid_rst_in_frame",  32'(in_frame),    32'h0);
    chk("mid_rst_mem_rd",    32'(m.mem_rd),    32'h0);
    chk("mid_rst_option",    32'(option),      32'h0);
    chk("mid_rst_fcnt",      32'(frame_count), 32'h0);
    chk("mid_rst_hsync_out", 32'(hsync_out),   32'h1);
    chk("mid_rst_vsync_out", 32'(vsync_out),   32'h1);
    chk("mid_rst_blank_out", 32'(blank_out),   32'h1);
    px(300, 200, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    option_req = 2'd0;
    for (int x = 301; x < 306; x++) px(x, 200, 1'b1, 1'b1, 1'b0);
    fs_pulse();
    chk("post_rst_fcnt", 32'(frame_count), 32'h1);
    t_e = c;
    px(64, 48, 1'b1, 1'b1, 1'b0);
    px(65, 48, 1'b1, 1'b1, 1'b0);
    px(66, 48, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) px(0, 48, 1'b1, 1'b1, 1'b1);
    chk("post_rst_addr0", 32'(r_addr[t_e+1]), 32'd0);
    chk("post_rst_rgb0",  32'(r_rgb[t_e+4]),  32'hA5A5A5);
    chk("post_rst_inf0",  32'(r_inf[t_e+4]),  32'd1);
    chk("post_rst_addr2", 32'(r_addr[t_e+3]), 32'd2);
    chk("post_rst_rgb2",  32'(r_rgb[t_e+6]),  32'hA5A5A7);

    // Option latch and frame counter wrap: reach 255, then request 3.
    for (int k = 0; k < 254; k++) fs_pulse();
    chk("fcnt_255",         32'(frame_count), 32'd255);
    option_req = 2'd3;
    for (int k = 0; k < 3; k++) px(0, 0, 1'b1, 1'b1, 1'b1);
    chk("opt_hold_midframe", 32'(option),      32'h0);
    chk("opt_hold_fcnt",     32'(frame_count), 32'd255);
    px(0, 0, 1'b1, 1'b0, 1'b1);
    chk("opt_latched",  32'(option),      32'h3);
    chk("fcnt_wrap",    32'(frame_count), 32'd0);
    px(0, 0, 1'b1, 1'b0, 1'b1);
    chk("fcnt_vs_held", 32'(frame_count), 32'd0);
    px(0, 0, 1'b1, 1'b1, 1'b1);

    // Small instance: one whole frame, address wrap, then the next frame.
    px2(0, 0, 1'b0);
    px2(0, 0, 1'b1);
    t_a = c;
    t_w = 0;
    for (int v = 0; v < 5; v++) begin
      for (int h = 0; h < 8; h++) begin
        if (h == 5 && v == 3) t_w = c;
        px2(h, v, 1'b1);
      end
    end
    n = 0;
    for (int k = t_a + 1; k <= t_a + 40; k++) n += int'(s_rd[k]);
    chk("small_rd_count", 32'(n), 32'd12);
    chk("small_last_addr", 32'(s_addr[t_w+1]), 32'd11);
    chk("small_last_rgb",  32'(s_rgb[t_w+3]),  32'hA5A5AE);
    chk("small_last_inf",  32'(s_inf[t_w+3]),  32'd1);
    // No frame start yet: the counter must already have wrapped to 0.
    t_b = c;
    px2(2, 1, 1'b1);
    px2(0, 0, 1'b1);
    chk("small_wrap_addr", 32'(s_addr[t_b+1]), 32'd0);
    px2(0, 0, 1'b0);
    px2(0, 0, 1'b1);
    t_b = c;
    px2(2, 1, 1'b1);
    px2(3, 1, 1'b1);
    for (int k = 0; k < 4; k++) px2(0, 0, 1'b1);
    chk("small_fs_addr0", 32'(s_addr[t_b+1]), 32'd0);
    chk("small_fs_addr1", 32'(s_addr[t_b+2]), 32'd1);
    chk("small_fs_rgb0",  32'(s_rgb[t_b+3]),  32'hA5A5A5);
    chk("small_fs_inf0",  32'(s_inf[t_b+3]),  32'd1);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_window_fetch.md
# video_window_fetch

Pixel-fetch stage placed directly upstream of the colour filter. It takes the XVGA raster position and sync signals and decides whether each pixel lies inside the display window. For in-window pixels it reads 24-bit RGB from the frame-buffer memory. It delivers `rgb`, `in_frame` and a frame-locked `option` to the filter, with the syncs and blank delayed by the same latency.

## Interface
Parameters:
- `X0`, 64: first window column (hcount)
- `Y0`, 48: first window row (vcount)
- `W`, 640: window width in pixels
- `H`, 480: window height in lines
- `MEM_LAT`, 2: frame-buffer read latency in cycles (≥1)
- `AW`, 19: address width; must satisfy 2^AW ≥ W*H

Ports:
- `clk`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `hcount`  in  11  raster column
- `vcount`  in  10  raster line
- `hsync_in`, `vsync_in`  in  1 each  active-low syncs
- `blank_in`  in  1  high = blanking
- `option_req`  in  2  requested filter option from the user interface
- `mem_addr`  out  AW  frame-buffer read address
- `mem_rd`  out  1  read strobe
- `mem_data`  in  24  read data; valid MEM_LAT cycles after the `mem_addr`/`mem_rd` cycle
- `rgb`  out  24  pixel to the filter
- `in_frame`  out  1  pixel inside the window
- `option`  out  2  filter option, constant for the whole frame
- `hsync_out`, `vsync_out`, `blank_out`  out  1 each  delayed syncs and blank
- `frame_count`  out  8  frame counter

## Operation
- Window test (combinational on inputs): `win = (X0 ≤ hcount < X0+W) && (Y0 ≤ vcount < Y0+H)`.
- Frame-start event `fs`: the first cycle with `vsync_in` low. It is detected against a registered copy of `vsync_in`.
- Address counter `acnt` (AW bits):
  - On `fs`: cleared to 0.
  - Otherwise, on a `win` cycle: increments by 1, and wraps from W*H−1 to 0.
  - Read stage: on each `win` cycle, register `mem_addr <= acnt` and `mem_rd <= 1`. On non-`win` cycles, `mem_rd <= 0` and `mem_addr` holds its value.
  - Result: pixel (X0+x, Y0+y) reads address y*W+x, with no multiplier.
- Alignment pipeline: `win`, `hsync_in`, `vsync_in` and `blank_in` are shifted through L = MEM_LAT+2 register stages.
- Output register:
  - `in_frame` = delayed `win`.
  - `rgb` = `mem_data` when the stage-(L−1) `win` is 1, else 24'h000000.
- Option latch: `option <= option_req` only on `fs`. At all other times `option` holds, so the filter never switches mid-frame.
- `frame_count` increments on each `fs` and wraps from 255 to 0.
- `fs` coinciding with `win`: not possible with legal parameters (window is inside the active region). If it does occur, the clear takes priority.
- Reset (any time, including mid-frame):
  - Cleared to 0: `acnt`, `mem_addr`, `mem_rd`, `rgb`, `in_frame`, `option`, `frame_count`, and all pipeline `win` bits.
  - Set to 1: pipeline sync bits, `hsync_out`, `vsync_out`, `blank_out`, and the registered `vsync_in`.
  - After reset is released: output is correct from the first `fs` onward.
  - Pixels of the partial frame in which reset occurred may use wrong addresses but are otherwise well-formed.

## Timing
- `mem_addr`/`mem_rd` appear 1 cycle after the corresponding `hcount`/`vcount` sample.
- `rgb`/`in_frame`/syncs/`blank_out` appear L = MEM_LAT+2 cycles after the input sample. With defaults, L = 4.
- Relative timing of the syncs, blank and `in_frame` is preserved exactly. Only a fixed L-cycle shift is added.
- `option` and `frame_count` update on the cycle after `fs` is detected. This is input-referenced, not L-delayed. The update falls in vertical blanking, so the filter sees a stable value for the whole frame.
- Throughput: one pixel per cycle, no stalls. The memory must accept a read every cycle.

## Test plan
- First pixel:
  - Stimulus: defaults, `fs`, then (hcount=64, vcount=48) at cycle t; memory model returns 24'hA5A5A5 for address 0.
  - Response: `mem_addr`=0, `mem_rd`=1 at t+1; `rgb`=A5A5A5, `in_frame`=1 at t+4.
- Row edges:
  - Stimulus: (703, 48), then (704, 48).
  - Response: (703, 48) reads addr 639. (704, 48) gives `mem_rd`=0 at t+1, and `in_frame`=0, `rgb`=0 at t+4.
  - Stimulus: (64, 49).
  - Response: reads addr 640.
- Frame end and wrap:
  - Stimulus: full frame.
  - Response: (703, 527) reads addr 307199. Exactly 307200 `mem_rd` pulses occur per frame. After the next `fs`, (64, 48) reads addr 0 again.
- Option latch:
  - Stimulus: `option_req` 0→3 mid-frame.
  - Response: `option` stays 0 through the rest of the frame, becomes 3 one cycle after `vsync_in` falls, and `frame_count` increments by 1. Start from `frame_count`=255; the response wraps to 0.
- Sync alignment:
  - Stimulus: random raster.
  - Response: `hsync_out`/`vsync_out`/`blank_out` equal the inputs delayed by exactly 4 cycles. `in_frame`=0 whenever the delayed `blank_out`=1.
- Reset mid-frame:
  - Stimulus: assert `reset` for 2 cycles at (300, 200).
  - Response:
    - Next cycle: `rgb`=0, `in_frame`=0, `mem_rd`=0, `option`=0, `frame_count`=0, and `hsync_out`/`vsync_out`/`blank_out`=1.
    - After the next `fs`: addresses restart at 0 and the output is correct.
